// File: rtl/bvb_stream.sv
// Broadcast vector buffer: streams vector-RAM sections, fans matching elements into per-channel FIFOs.
// Issue to val_empty low is 2 edges; a full output FIFO stalls its id until the section comes round again.
module bvb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_rdy & ~empty;
  // Head is forced to zero when empty so reset presents a clean output.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module bvb_stream #(
  parameter int CHANNEL_NUM  = 4,
  parameter int COL_ID_SIZE  = 10,
  parameter int VAL_BITS     = 8,
  parameter int SECTION_BITS = 3,
  parameter int ADDR_BITS    = 7,
  parameter int OUT_DEPTH    = 4,
  parameter int SKIP_MODE    = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              enable,
  input  logic [ADDR_BITS-1:0]                              image_base,
  output logic                                              ram_en,
  output logic [ADDR_BITS-1:0]                              ram_addr,
  input  logic [(1<<(COL_ID_SIZE-SECTION_BITS))*VAL_BITS-1:0] ram_rdata,
  input  logic [CHANNEL_NUM*COL_ID_SIZE-1:0]                id,
  input  logic [CHANNEL_NUM-1:0]                            id_empty,
  output logic [CHANNEL_NUM-1:0]                            id_read,
  output logic [CHANNEL_NUM*VAL_BITS-1:0]                   val,
  output logic [CHANNEL_NUM-1:0]                            val_empty,
  input  logic [CHANNEL_NUM-1:0]                            val_read
);
  localparam int SECTIONS = 1 << SECTION_BITS;
  localparam int OFF_BITS = COL_ID_SIZE - SECTION_BITS;

  logic [SECTION_BITS-1:0] cur_sec;
  logic [SECTION_BITS-1:0] issue_sec;
  logic [SECTION_BITS-1:0] tag_sec;
  logic                    tag_valid;
  logic                    issue_vld;
  logic [SECTIONS-1:0]     pending;
  logic [SECTION_BITS-1:0] head_sec [CHANNEL_NUM];
  logic [OFF_BITS-1:0]     head_off [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0]  fifo_full;
  logic [CHANNEL_NUM-1:0]  capture;

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_head
    assign head_sec[i] = id[i*COL_ID_SIZE + OFF_BITS +: SECTION_BITS];
    assign head_off[i] = id[i*COL_ID_SIZE +: OFF_BITS];
  end

  always_comb begin
    pending = '0;
    for (int s = 0; s < SECTIONS; s++) begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        if (!id_empty[i] && head_sec[i] == SECTION_BITS'(s)) pending[s] = 1'b1;
      end
    end
  end

  // Skip mode scans cur+SECTIONS down to cur+1 so the nearest successor wins and cur comes last.
  always_comb begin
    issue_sec = cur_sec;
    issue_vld = 1'b1;
    if (SKIP_MODE != 0) begin
      issue_vld = 1'b0;
      for (int k = SECTIONS; k >= 1; k--) begin
        if (pending[cur_sec + SECTION_BITS'(k)]) begin
          issue_sec = cur_sec + SECTION_BITS'(k);
          issue_vld = 1'b1;
        end
      end
    end
  end

  assign ram_en   = enable & issue_vld & ~rst;
  assign ram_addr = image_base + ADDR_BITS'(issue_sec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sec   <= '0;
      tag_valid <= 1'b0;
      tag_sec   <= '0;
    end else begin
      tag_valid <= ram_en;
      tag_sec   <= issue_sec;
      if (ram_en) cur_sec <= (SKIP_MODE != 0) ? issue_sec : issue_sec + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_ch
    logic [VAL_BITS-1:0] cap_dat;

    assign capture[i] = tag_valid & ~id_empty[i] & (head_sec[i] == tag_sec) & ~fifo_full[i];
    assign cap_dat    = ram_rdata[32'(head_off[i]) * VAL_BITS +: VAL_BITS];

    bvb_fifo #(
      .WIDTH (VAL_BITS),
      .DEPTH (OUT_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (capture[i]),
      .push_dat (cap_dat),
      .pop_rdy  (val_read[i]),
      .head_dat (val[i*VAL_BITS +: VAL_BITS]),
      .empty    (val_empty[i]),
      .full     (fifo_full[i])
    );
  end

  assign id_read = capture;
endmodule

// File: tb/tb_bvb_stream.sv
// Bench for bvb_stream: round-robin instance [0] and skip-mode instance [1] share clock and reset.
module tb_bvb_stream;
  localparam int CH = 4, CW = 10, VB = 8, SB = 3, AB = 7;
  localparam int OB = CW - SB;
  localparam int W  = (1 << OB) * VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              enable     [2];
  logic [AB-1:0]     image_base [2];
  logic              ram_en     [2];
  logic [AB-1:0]     ram_addr   [2];
  logic [W-1:0]      ram_rdata  [2];
  logic [CH*CW-1:0]  id         [2];
  logic [CH-1:0]     id_empty   [2];
  logic [CH-1:0]     id_read    [2];
  logic [CH*VB-1:0]  val        [2];
  logic [CH-1:0]     val_empty  [2];
  logic [CH-1:0]     val_read   [2];

  bvb_stream #(.SKIP_MODE(0)) u_rr (
    .clk(clk), .rst(rst), .enable(enable[0]), .image_base(image_base[0]),
    .ram_en(ram_en[0]), .ram_addr(ram_addr[0]), .ram_rdata(ram_rdata[0]),
    .id(id[0]), .id_empty(id_empty[0]), .id_read(id_read[0]),
    .val(val[0]), .val_empty(val_empty[0]), .val_read(val_read[0])
  );

  bvb_stream #(.SKIP_MODE(1)) u_skip (
    .clk(clk), .rst(rst), .enable(enable[1]), .image_base(image_base[1]),
    .ram_en(ram_en[1]), .ram_addr(ram_addr[1]), .ram_rdata(ram_rdata[1]),
    .id(id[1]), .id_empty(id_empty[1]), .id_read(id_read[1]),
    .val(val[1]), .val_empty(val_empty[1]), .val_read(val_read[1])
  );

  function automatic logic [VB-1:0] ram_byte(logic [AB-1:0] a, int b);
    int v;
    v = (int'(a) * 29) ^ (b * 7) ^ 1;
    return v[7:0];
  endfunction

  function automatic logic [W-1:0] ram_word(logic [AB-1:0] a);
    logic [W-1:0] w;
    for (int b = 0; b < (1 << OB); b++) w[b*VB +: VB] = ram_byte(a, b);
    return w;
  endfunction

  // Vector RAM: data one cycle after ram_en, inverted garbage otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      ram_rdata[d] <= ram_en[d] ? ram_word(ram_addr[d]) : ~ram_word(ram_addr[d]);
  end

  logic [CW-1:0] idq  [2][CH][$];
  logic [VB-1:0] expq [2][CH][$];

  int n_vec = 0;
  int n_err = 0;

  logic          s_ram_en    [2];
  logic [AB-1:0] s_ram_addr  [2];
  logic [CH-1:0] s_id_read   [2];
  logic [CH-1:0] s_val_empty [2];
  logic [CH*VB-1:0] s_val    [2];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [VB-1:0] model(int d, logic [CW-1:0] cid);
    return ram_byte(image_base[d] + AB'(cid[CW-1:OB]), int'(cid[OB-1:0]));
  endfunction

  task automatic push_id(int d, int c, logic [CW-1:0] cid, logic [VB-1:0] exp);
    idq[d][c].push_back(cid);
    expq[d][c].push_back(exp);
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (idq[d][c].size() != 0) begin
          id[d][c*CW +: CW] = idq[d][c][0];
          id_empty[d][c]    = 1'b0;
        end else begin
          id[d][c*CW +: CW] = '0;
          id_empty[d][c]    = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive id heads, sample mid-cycle, retire pops in the model, advance to next negedge.
  task automatic step();
    drive();
    #1;
    for (int d = 0; d < 2; d++) begin
      s_ram_en[d]    = ram_en[d];
      s_ram_addr[d]  = ram_addr[d];
      s_id_read[d]   = id_read[d];
      s_val_empty[d] = val_empty[d];
      s_val[d]       = val[d];
      for (int c = 0; c < CH; c++) begin
        if (id_read[d][c]) begin
          if (idq[d][c].size() == 0) chk("spurious_id_read", 1, 0);
          else void'(idq[d][c].pop_front());
        end
        if (val_read[d][c] && !val_empty[d][c]) begin
          if (expq[d][c].size() == 0) chk("unexpected_val", 1, 0);
          else chk("scoreboard_val", val[d][c*VB +: VB], expq[d][c].pop_front());
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_queues(int d);
    for (int c = 0; c < CH; c++) begin
      idq[d][c].delete();
      expq[d][c].delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      enable[d]   = 1'b0;
      val_read[d] = '0;
      clear_queues(d);
    end
    drive();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int outstanding(int d);
    int n = 0;
    for (int c = 0; c < CH; c++) n += idq[d][c].size() + expq[d][c].size();
    return n;
  endfunction

  task automatic drain(int d, int max);
    val_read[d] = '1;
    for (int k = 0; k < max; k++) begin
      if (outstanding(d) == 0) break;
      step();
    end
    val_read[d] = '0;
    chk("drain_outstanding", outstanding(d), 0);
  endtask

  typedef struct {
    int            ch;
    logic [CW-1:0] cid;
    logic [VB-1:0] exp;
  } vec_t;

  vec_t          tbl [8];
  logic [AB-1:0] wrap_exp [9];
  logic [SB-1:0] skip_exp [6];
  logic [VB-1:0] bc_exp [4];
  logic [CW-1:0] bc_id [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
    $fatal(1);
  end

  initial begin
    int found, acc;
    logic [CW-1:0] cid;

    for (int d = 0; d < 2; d++) begin
      enable[d]     = 1'b1;
      image_base[d] = '0;
      id[d]         = '0;
      id_empty[d]   = '1;
      val_read[d]   = '0;
    end

    // Reset state with enable already high.
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_val_empty", val_empty[d], 4'hF);
      chk("reset_id_read", id_read[d], 4'h0);
      chk("reset_ram_en", ram_en[d], 1'b0);
      chk("reset_val", val[d], '0);
    end
    @(negedge clk);

    // Single hit: base 5, id 0x0A3 -> section 1 at addr 6, byte 35.
    do_reset();
    image_base[0] = 7'd5;
    push_id(0, 0, 10'h0A3, model(0, 10'h0A3));
    enable[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (s_ram_en[0] && s_ram_addr[0] == 7'd6) found = 1;
    end
    chk("hit_issue_addr6", found, 1);
    chk("hit_no_early_read", s_id_read[0], 4'h0);
    step();
    chk("hit_id_read", s_id_read[0], 4'b0001);
    step();
    chk("hit_id_read_single", s_id_read[0], 4'b0000);
    chk("hit_val_empty", s_val_empty[0][0], 1'b0);
    chk("hit_val", s_val[0][7:0], 8'h5A);
    val_read[0] = 4'b0001;
    step();
    val_read[0] = '0;
    chk("hit_popped", expq[0][0].size(), 0);

    // Table-driven single hits on several channels.
    do_reset();
    image_base[0] = 7'h11;
    tbl[0] = '{0, 10'h005, 8'h00}; tbl[1] = '{1, 10'h0FF, 8'h00};
    tbl[2] = '{2, 10'h37F, 8'h00}; tbl[3] = '{3, 10'h200, 8'h00};
    tbl[4] = '{1, 10'h2AA, 8'h00}; tbl[5] = '{0, 10'h3C0, 8'h00};
    tbl[6] = '{2, 10'h155, 8'h00}; tbl[7] = '{3, 10'h07F, 8'h00};
    for (int v = 0; v < 8; v++) tbl[v].exp = model(0, tbl[v].cid);
    enable[0] = 1'b1;
    for (int v = 0; v < 8; v++) begin
      push_id(0, tbl[v].ch, tbl[v].cid, tbl[v].exp);
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
        step();
        if (!s_val_empty[0][tbl[v].ch]) found = 1;
      end
      chk("vec_arrived", found, 1);
      chk("vec_val", s_val[0][tbl[v].ch*VB +: VB], tbl[v].exp);
      val_read[0][tbl[v].ch] = 1'b1;
      step();
      val_read[0] = '0;
    end

    // Address wrap at the top of RAM, then enable low holds the counter.
    do_reset();
    image_base[0] = 7'h7E;
    wrap_exp = '{7'h7E, 7'h7F, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h7E};
    enable[0] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("wrap_addr", s_ram_addr[0], wrap_exp[k]);
      chk("wrap_en", s_ram_en[0], 1'b1);
    end
    enable[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("hold_en", s_ram_en[0], 1'b0);
      chk("hold_addr", s_ram_addr[0], 7'h7F);
    end
    enable[0] = 1'b1;
    step();
    chk("resume_addr", s_ram_addr[0], 7'h7F);

    // Backpressure: 6 ids for ch1 in section 2, depth 4, no pops.
    do_reset();
    image_base[0] = 7'h30;
    for (int k = 0; k < 6; k++) begin
      cid = {3'd2, 7'(k + 1)};
      push_id(0, 1, cid, model(0, cid));
    end
    enable[0] = 1'b1;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      acc += int'(s_id_read[0][1]);
    end
    chk("bp_accepted_4", acc, 4);
    chk("bp_ch1_nonempty", s_val_empty[0][1], 1'b0);
    val_read[0] = 4'b0010;
    step();
    val_read[0] = '0;
    acc = int'(s_id_read[0][1]);
    for (int k = 0; k < 10; k++) begin
      step();
      acc += int'(s_id_read[0][1]);
    end
    chk("bp_fifth_accepted", acc, 1);
    drain(0, 80);

    // Broadcast: all channels hit section 3 in the same cycle.
    do_reset();
    image_base[0] = 7'h40;
    bc_id = '{10'h180, 10'h181, 10'h1C0, 10'h1FF};
    for (int c = 0; c < CH; c++) begin
      bc_exp[c] = model(0, bc_id[c]);
      push_id(0, c, bc_id[c], bc_exp[c]);
    end
    enable[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (s_id_read[0] != '0) found = 1;
    end
    chk("bcast_id_read", s_id_read[0], 4'hF);
    step();
    for (int c = 0; c < CH; c++) chk("bcast_val", s_val[0][c*VB +: VB], bc_exp[c]);
    drain(0, 20);
    enable[0] = 1'b0;

    // Skip mode: heads only in sections 2 and 6.
    do_reset();
    image_base[1] = 7'h20;
    enable[1]     = 1'b1;
    val_read[1]   = '1;
    step();
    chk("skip_idle_en", s_ram_en[1], 1'b0);
    chk("skip_idle_addr", s_ram_addr[1], 7'h20);
    for (int k = 0; k < 3; k++) begin
      cid = {3'd2, 7'(10 + k)};
      push_id(1, 0, cid, model(1, cid));
      cid = {3'd6, 7'(20 + k)};
      push_id(1, 1, cid, model(1, cid));
    end
    skip_exp = '{3'd2, 3'd6, 3'd2, 3'd6, 3'd2, 3'd6};
    for (int k = 0; k < 6; k++) begin
      step();
      chk("skip_en", s_ram_en[1], 1'b1);
      chk("skip_section", AB'(s_ram_addr[1] - image_base[1]), AB'(skip_exp[k]));
    end
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("skip_empty_en", s_ram_en[1], 1'b0);
      chk("skip_empty_hold", s_ram_addr[1], 7'h26);
    end
    drain(1, 20);

    // Asynchronous reset mid-stream with two values buffered and a capture in progress.
    do_reset();
    image_base[0] = 7'd5;
    for (int k = 0; k < 3; k++) begin
      cid = {3'd1, 7'(k + 1)};
      push_id(0, 0, cid, model(0, cid));
    end
    enable[0] = 1'b1;
    for (int k = 0; k < 30 && idq[0][0].size() > 1; k++) step();
    chk("rst_two_buffered", idq[0][0].size(), 1);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step();
      if (s_ram_en[0] && s_ram_addr[0] == 7'd6) found = 1;
    end
    drive();
    #1;
    chk("rst_pre_id_read", id_read[0], 4'b0001);
    #2;
    rst       = 1'b1;
    enable[0] = 1'b0;
    #1;
    chk("rst_async_val_empty", val_empty[0], 4'hF);
    chk("rst_async_id_read", id_read[0], 4'h0);
    chk("rst_async_ram_en", ram_en[0], 1'b0);
    chk("rst_async_val", val[0], '0);
    clear_queues(0);
    @(negedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    step();
    chk("rst_release_addr", s_ram_addr[0], 7'd5);
    chk("rst_release_val_empty", s_val_empty[0], 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
